// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial_deser receive stage.
// Optional even-parity support is selected with the PARITY_EN macro.
package serial_deser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam int   SYNC_STAGES = 2;
  localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/serial_deser_if.sv
// Word-delivery channel of serial_deser: valid/ready handshake plus status flags.
// parity_err is only live when PARITY_EN is defined.
interface serial_deser_if
  import serial_deser_pkg::*;
#(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  modport master (output data, valid, frame_err, overrun, parity_err, input ready);
  modport slave  (input data, valid, frame_err, overrun, parity_err, output ready);
endinterface

// File: rtl/serial_deser_sync_2ff.sv
// Two-flop synchronizer for the serial line; resets to the idle line level.
module sync_2ff
  import serial_deser_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!reset) chain <= {SYNC_STAGES{LINE_IDLE}};
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/serial_deser.sv
// Framed NRZ receiver: start detect, LSB-first shift, stop check, valid/ready output.
// Define PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int DATA_W = 8
)
(
  input  logic           clk,
  input  logic           reset,
  input  logic           d,
  serial_deser_if.master rx
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              s;
  state_t            state, state_n;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              shift, load, drop, par_bad;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (s)
  );

`ifdef PARITY_EN
  logic par_bit;
  assign par_bad = ^{sr, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    shift   = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    case (state)
      ST_IDLE: if (!s) state_n = ST_DATA;
      ST_DATA: begin
        shift = 1'b1;
        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_EN
          state_n = ST_PARITY;
`else
          state_n = ST_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      ST_PARITY: state_n = ST_STOP;
`endif
      ST_STOP: begin
        if (s) begin
          state_n = ST_IDLE;
          if (!par_bad) begin
            // A transfer on this same edge frees the holding register for the new word.
            if (rx.valid && !rx.ready) drop = 1'b1;
            else                       load = 1'b1;
          end
        end else begin
          state_n = ST_BREAK;
        end
      end
      ST_BREAK: if (s) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      rx.data      <= '0;
      rx.valid     <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      state        <= state_n;
      rx.frame_err <= (state == ST_STOP) && !s;
      if (state == ST_IDLE) bit_cnt <= '0;
      if (shift) begin
        sr      <= {s, sr[DATA_W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (load) begin
        rx.data  <= sr;
        rx.valid <= 1'b1;
      end else if (rx.valid && rx.ready) begin
        rx.valid <= 1'b0;
      end
      if (drop) rx.overrun <= 1'b1;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      par_bit       <= 1'b0;
      rx.parity_err <= 1'b0;
    end else begin
      if (state == ST_PARITY) par_bit <= s;
      rx.parity_err <= (state == ST_STOP) && s && par_bad;
    end
  end
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: table of single frames plus hand-written
// sequences for overrun, same-edge handoff, line break, mid-frame reset and parity.
module tb_serial_deser;
  logic clk;
  logic reset;
  logic d;
  int   n_checks;
  int   n_fail;

  serial_deser_if #(.DATA_W(8)) rx ();

  serial_deser #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .rx    (rx)
  );

  always #5 clk = ~clk;

`ifdef PARITY_EN
  logic par_flip = 1'b0;
`endif

  typedef struct {
    logic [7:0] word;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    d = b;
  endtask

  task automatic drive_frame(input logic [7:0] w, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(w[i]);
`ifdef PARITY_EN
    drive_bit((^w) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  // Three negedges after the stop bit is driven: outputs then reflect the stop edge.
  task automatic tail(input logic line, input logic ready_before_load);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      d = line;
      if (i == 2 && ready_before_load) rx.ready = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    d     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic       seen_valid;
    logic [7:0] w;
    clk      = 1'b0;
    reset    = 1'b0;
    d        = 1'b1;
    rx.ready = 1'b0;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 8'h3C, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(rx.valid), 32'd0);
    check("reset_data", 32'(rx.data), 32'd0);
    check("reset_ferr", 32'(rx.frame_err), 32'd0);
    check("reset_overrun", 32'(rx.overrun), 32'd0);
    check("reset_perr", 32'(rx.parity_err), 32'd0);
    reset = 1'b1;

    // Table: single frames with ready held high
    rx.ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_frame(vecs[v].word, vecs[v].stop);
      tail(1'b1, 1'b0);
      check($sformatf("vec%0d_valid", v), 32'(rx.valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), 32'(rx.data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_ferr", v), 32'(rx.frame_err), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_perr", v), 32'(rx.parity_err), 32'd0);
      check($sformatf("vec%0d_overrun", v), 32'(rx.overrun), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_valid_next", v), 32'(rx.valid), 32'd0);
      check($sformatf("vec%0d_ferr_next", v), 32'(rx.frame_err), 32'd0);
    end

    // Back-to-back frames with ready low: second is dropped, overrun is sticky
    do_reset();
    rx.ready = 1'b0;
    drive_frame(8'h3C, 1'b1);
    drive_frame(8'hC3, 1'b1);
    tail(1'b1, 1'b0);
    check("ovr_data", 32'(rx.data), 32'h3C);
    check("ovr_valid", 32'(rx.valid), 32'd1);
    check("ovr_flag", 32'(rx.overrun), 32'd1);
    rx.ready = 1'b1;
    @(negedge clk);
    rx.ready = 1'b0;
    check("ovr_consumed", 32'(rx.valid), 32'd0);
    check("ovr_sticky", 32'(rx.overrun), 32'd1);

    // New word completes on the same edge that consumes the old one
    do_reset();
    check("rst2_overrun", 32'(rx.overrun), 32'd0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_frame(8'h3C, 1'b1);
    tail(1'b1, 1'b0);
    check("hand_first_data", 32'(rx.data), 32'h3C);
    drive_frame(8'h5A, 1'b1);
    tail(1'b1, 1'b1);
    rx.ready = 1'b0;
    check("hand_data", 32'(rx.data), 32'h5A);
    check("hand_valid", 32'(rx.valid), 32'd1);
    check("hand_overrun", 32'(rx.overrun), 32'd0);
    @(negedge clk);
    check("hand_valid_hold", 32'(rx.valid), 32'd1);
    rx.ready = 1'b1;
    @(negedge clk);
    check("hand_drain", 32'(rx.valid), 32'd0);

    // Bad stop bit, then line held low: no retrigger until it returns high
    drive_frame(8'hFF, 1'b0);
    tail(1'b0, 1'b0);
    check("brk_ferr", 32'(rx.frame_err), 32'd1);
    check("brk_valid", 32'(rx.valid), 32'd0);
    drive_bit(1'b0);
    check("brk_ferr_pulse", 32'(rx.frame_err), 32'd0);
    drive_bit(1'b0);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_bit(1'b1);
      if (rx.valid || rx.frame_err) seen_valid = 1'b1;
    end
    check("brk_no_frame", 32'(seen_valid), 32'd0);
    drive_frame(8'h42, 1'b1);
    tail(1'b1, 1'b0);
    check("brk_recover_data", 32'(rx.data), 32'h42);
    check("brk_recover_valid", 32'(rx.valid), 32'd1);

    // Reset at bit 4 of a frame; remaining bits are 1 so nothing looks like a start
    w = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(w[i]);
    @(negedge clk);
    reset = 1'b0;
    d     = w[4];
    @(negedge clk);
    d = w[5];
    check("mid_rst_valid", 32'(rx.valid), 32'd0);
    check("mid_rst_data", 32'(rx.data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    d     = w[6];
    drive_bit(w[7]);
    drive_bit(1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b1);
      if (rx.valid || rx.frame_err) seen_valid = 1'b1;
    end
    check("mid_rst_abandon", 32'(seen_valid), 32'd0);
    drive_frame(8'h81, 1'b1);
    tail(1'b1, 1'b0);
    check("mid_rst_next_data", 32'(rx.data), 32'h81);
    check("mid_rst_next_valid", 32'(rx.valid), 32'd1);

`ifdef PARITY_EN
    @(negedge clk);
    par_flip = 1'b1;
    drive_bit(1'b1);
    drive_frame(8'h07, 1'b1);
    tail(1'b1, 1'b0);
    check("par_bad_perr", 32'(rx.parity_err), 32'd1);
    check("par_bad_valid", 32'(rx.valid), 32'd0);
    check("par_bad_data", 32'(rx.data), 32'h81);
    check("par_bad_overrun", 32'(rx.overrun), 32'd0);
    @(negedge clk);
    check("par_bad_pulse", 32'(rx.parity_err), 32'd0);
    par_flip = 1'b0;
    drive_frame(8'h07, 1'b1);
    tail(1'b1, 1'b0);
    check("par_ok_data", 32'(rx.data), 32'h07);
    check("par_ok_valid", 32'(rx.valid), 32'd1);
    check("par_ok_perr", 32'(rx.parity_err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
